// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int XLEN          = 32;
    localparam int REG_W         = 5;

    // A committed entry updates the register file only when it produced a value
    // for a real register and was not a mispredicted branch.
    function automatic logic rf_write_needed(
        input logic             mispredict,
        input logic             has_dest,
        input logic [REG_W-1:0] reg_id
    );
        return !mispredict && has_dest && (reg_id != '0);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates nonzero tags, captures CDB results, retires
// the head to the register file and flushes on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int ROB_DEPTH = (1 << ROB_WIDTH) - 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 from_decoder_valid,
    input  logic                 from_decoder_has_dest,
    input  logic [REG_W-1:0]     from_decoder_reg_id,
    input  logic                 from_decoder_is_branch,
    output logic [ROB_WIDTH-1:0] to_decoder_rob_id,
    output logic                 to_decoder_full,
    input  logic                 from_cdb_valid,
    input  logic [ROB_WIDTH-1:0] from_cdb_rob_id,
    input  logic [XLEN-1:0]      from_cdb_data,
    input  logic                 from_cdb_mispredict,
    input  logic [XLEN-1:0]      from_cdb_target,
    input  logic [ROB_WIDTH-1:0] query_rob_id_a,
    input  logic [ROB_WIDTH-1:0] query_rob_id_b,
    output logic                 query_ready_a,
    output logic                 query_ready_b,
    output logic [XLEN-1:0]      query_data_a,
    output logic [XLEN-1:0]      query_data_b,
    output logic                 to_rf_write_enabled,
    output logic [REG_W-1:0]     to_rf_reg_id,
    output logic [XLEN-1:0]      to_rf_data,
    output logic [ROB_WIDTH-1:0] to_rf_rob_id,
    output logic                 flush_output,
    output logic [XLEN-1:0]      flush_pc
);

    localparam logic [ROB_WIDTH-1:0] L_DEPTH = ROB_WIDTH'(ROB_DEPTH);
    localparam logic [ROB_WIDTH-1:0] L_LAST  = ROB_WIDTH'(ROB_DEPTH - 1);
    localparam logic [ROB_WIDTH-1:0] L_ONE   = ROB_WIDTH'(1);

    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_ready;
    logic [ROB_DEPTH-1:0] r_has_dest;
    logic [ROB_DEPTH-1:0] r_is_branch;
    logic [ROB_DEPTH-1:0] r_mispredict;
    logic [REG_W-1:0]     r_reg_id [ROB_DEPTH];
    logic [XLEN-1:0]      r_data   [ROB_DEPTH];
    logic [XLEN-1:0]      r_target [ROB_DEPTH];

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH-1:0] r_count;

    logic                 r_rf_we;
    logic [REG_W-1:0]     r_rf_reg_id;
    logic [XLEN-1:0]      r_rf_data;
    logic [ROB_WIDTH-1:0] r_rf_rob_id;
    logic                 r_flush;
    logic [XLEN-1:0]      r_flush_pc;

    logic                 w_alloc;
    logic                 w_commit;
    logic                 w_flush;
    logic                 w_cdb_hit;
    logic [ROB_WIDTH-1:0] w_cdb_idx;
    logic [ROB_WIDTH-1:0] w_qa_idx;
    logic [ROB_WIDTH-1:0] w_qb_idx;

    function automatic logic [ROB_WIDTH-1:0] next_ptr(input logic [ROB_WIDTH-1:0] p);
        return (p == L_LAST) ? '0 : p + L_ONE;
    endfunction

    assign to_decoder_rob_id = r_tail + L_ONE;
    assign to_decoder_full   = (r_count == L_DEPTH) | r_flush;

    assign w_alloc   = from_decoder_valid & ~to_decoder_full;
    assign w_commit  = r_busy[r_head] & r_ready[r_head] & (r_count != '0);
    // A mispredict flag only matters on entries that were dispatched as branches.
    assign w_flush   = w_commit & r_mispredict[r_head] & r_is_branch[r_head];
    assign w_cdb_idx = from_cdb_rob_id - L_ONE;
    assign w_cdb_hit = from_cdb_valid & (from_cdb_rob_id != '0) & r_busy[w_cdb_idx];

    // Operand lookups read stored state only; a result on the CDB this cycle is not forwarded.
    assign w_qa_idx      = query_rob_id_a - L_ONE;
    assign w_qb_idx      = query_rob_id_b - L_ONE;
    assign query_ready_a = (query_rob_id_a != '0) & r_busy[w_qa_idx] & r_ready[w_qa_idx];
    assign query_ready_b = (query_rob_id_b != '0) & r_busy[w_qb_idx] & r_ready[w_qb_idx];
    assign query_data_a  = (query_rob_id_a != '0) ? r_data[w_qa_idx] : '0;
    assign query_data_b  = (query_rob_id_b != '0) ? r_data[w_qb_idx] : '0;

    assign to_rf_write_enabled = r_rf_we;
    assign to_rf_reg_id        = r_rf_reg_id;
    assign to_rf_data          = r_rf_data;
    assign to_rf_rob_id        = r_rf_rob_id;
    assign flush_output        = r_flush;
    assign flush_pc            = r_flush_pc;

    // Entry storage, pointers and registered commit/flush outputs; flush overrides everything else.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_has_dest   <= '0;
            r_is_branch  <= '0;
            r_mispredict <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_reg_id[i] <= '0;
                r_data[i]   <= '0;
                r_target[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rf_we     <= 1'b0;
            r_rf_reg_id <= '0;
            r_rf_data   <= '0;
            r_rf_rob_id <= '0;
            r_flush     <= 1'b0;
            r_flush_pc  <= '0;
        end else begin
            r_rf_we <= 1'b0;
            r_flush <= 1'b0;
            if (w_flush) begin
                r_busy     <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_flush    <= 1'b1;
                r_flush_pc <= r_target[r_head];
            end else begin
                if (w_cdb_hit) begin
                    r_ready[w_cdb_idx]      <= 1'b1;
                    r_data[w_cdb_idx]       <= from_cdb_data;
                    r_mispredict[w_cdb_idx] <= from_cdb_mispredict;
                    r_target[w_cdb_idx]     <= from_cdb_target;
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= next_ptr(r_head);
                    if (rf_write_needed(r_mispredict[r_head], r_has_dest[r_head], r_reg_id[r_head])) begin
                        r_rf_we     <= 1'b1;
                        r_rf_reg_id <= r_reg_id[r_head];
                        r_rf_data   <= r_data[r_head];
                        r_rf_rob_id <= r_head + L_ONE;
                    end
                end
                if (w_alloc) begin
                    r_busy[r_tail]       <= 1'b1;
                    r_ready[r_tail]      <= 1'b0;
                    r_has_dest[r_tail]   <= from_decoder_has_dest;
                    r_is_branch[r_tail]  <= from_decoder_is_branch;
                    r_mispredict[r_tail] <= 1'b0;
                    r_reg_id[r_tail]     <= from_decoder_reg_id;
                    r_tail               <= next_ptr(r_tail);
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + L_ONE;
                    2'b01:   r_count <= r_count - L_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        from_decoder_valid;
    logic        from_decoder_has_dest;
    logic [4:0]  from_decoder_reg_id;
    logic        from_decoder_is_branch;
    logic [3:0]  to_decoder_rob_id;
    logic        to_decoder_full;
    logic        from_cdb_valid;
    logic [3:0]  from_cdb_rob_id;
    logic [31:0] from_cdb_data;
    logic        from_cdb_mispredict;
    logic [31:0] from_cdb_target;
    logic [3:0]  query_rob_id_a;
    logic [3:0]  query_rob_id_b;
    logic        query_ready_a;
    logic        query_ready_b;
    logic [31:0] query_data_a;
    logic [31:0] query_data_b;
    logic        to_rf_write_enabled;
    logic [4:0]  to_rf_reg_id;
    logic [31:0] to_rf_data;
    logic [3:0]  to_rf_rob_id;
    logic        flush_output;
    logic [31:0] flush_pc;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  reg_id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   commit_cyc[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [3:0] model_tag;

    reorder_buffer dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .from_decoder_valid     (from_decoder_valid),
        .from_decoder_has_dest  (from_decoder_has_dest),
        .from_decoder_reg_id    (from_decoder_reg_id),
        .from_decoder_is_branch (from_decoder_is_branch),
        .to_decoder_rob_id      (to_decoder_rob_id),
        .to_decoder_full        (to_decoder_full),
        .from_cdb_valid         (from_cdb_valid),
        .from_cdb_rob_id        (from_cdb_rob_id),
        .from_cdb_data          (from_cdb_data),
        .from_cdb_mispredict    (from_cdb_mispredict),
        .from_cdb_target        (from_cdb_target),
        .query_rob_id_a         (query_rob_id_a),
        .query_rob_id_b         (query_rob_id_b),
        .query_ready_a          (query_ready_a),
        .query_ready_b          (query_ready_b),
        .query_data_a           (query_data_a),
        .query_data_b           (query_data_b),
        .to_rf_write_enabled    (to_rf_write_enabled),
        .to_rf_reg_id           (to_rf_reg_id),
        .to_rf_data             (to_rf_data),
        .to_rf_rob_id           (to_rf_rob_id),
        .flush_output           (flush_output),
        .flush_pc               (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare any register-file write against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk_in);
        #1;
        cyc++;
        if (to_rf_write_enabled === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("commit_unexpected", to_rf_write_enabled, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("commit_rob_id", to_rf_rob_id, e.tag);
                check("commit_reg_id", to_rf_reg_id, e.reg_id);
                check("commit_data", to_rf_data, e.data);
                commit_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in    = 1'b1;
        model_tag = 4'd1;
        exp_q.delete();
        commit_cyc.delete();
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic hd, input logic br,
                            input logic exp_commit, input logic [31:0] d);
        exp_t e;
        check("alloc_tag", to_decoder_rob_id, model_tag);
        check("alloc_not_full", to_decoder_full, 1'b0);
        from_decoder_valid     = 1'b1;
        from_decoder_has_dest  = hd;
        from_decoder_reg_id    = rd;
        from_decoder_is_branch = br;
        if (exp_commit) begin
            e.tag    = model_tag;
            e.reg_id = rd;
            e.data   = d;
            exp_q.push_back(e);
        end
        tick();
        from_decoder_valid = 1'b0;
        model_tag = (model_tag == 4'd15) ? 4'd1 : model_tag + 4'd1;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] d,
                       input logic misp, input logic [31:0] tgt);
        from_cdb_valid      = 1'b1;
        from_cdb_rob_id     = tag;
        from_cdb_data       = d;
        from_cdb_mispredict = misp;
        from_cdb_target     = tgt;
        tick();
        from_cdb_valid      = 1'b0;
        from_cdb_mispredict = 1'b0;
    endtask

    initial begin
        rst_in                 = 1'b1;
        from_decoder_valid     = 1'b0;
        from_decoder_has_dest  = 1'b0;
        from_decoder_reg_id    = '0;
        from_decoder_is_branch = 1'b0;
        from_cdb_valid         = 1'b0;
        from_cdb_rob_id        = '0;
        from_cdb_data          = '0;
        from_cdb_mispredict    = 1'b0;
        from_cdb_target        = '0;
        query_rob_id_a         = '0;
        query_rob_id_b         = '0;
        model_tag              = 4'd1;
        #2;
        rst_in = 1'b0;
        #1;
        check("rst_rf_we", to_rf_write_enabled, 1'b0);
        check("rst_rf_reg", to_rf_reg_id, 5'd0);
        check("rst_rf_data", to_rf_data, 32'd0);
        check("rst_rf_rob", to_rf_rob_id, 4'd0);
        check("rst_flush", flush_output, 1'b0);
        check("rst_flush_pc", flush_pc, 32'd0);
        check("rst_rob_id", to_decoder_rob_id, 4'd1);
        check("rst_full", to_decoder_full, 1'b0);
        do_reset();

        // In-order commit of out-of-order completions
        dispatch(5'd1, 1'b1, 1'b0, 1'b1, 32'h10);
        dispatch(5'd2, 1'b1, 1'b0, 1'b1, 32'h20);
        dispatch(5'd3, 1'b1, 1'b0, 1'b1, 32'h30);
        cdb(4'd3, 32'h30, 1'b0, 32'h0);
        cdb(4'd1, 32'h10, 1'b0, 32'h0);
        cdb(4'd2, 32'h20, 1'b0, 32'h0);
        repeat (3) tick();
        check("t1_pending", exp_q.size(), 0);
        check("t1_commits", commit_cyc.size(), 3);
        if (commit_cyc.size() == 3) begin
            check("t1_back2back_a", commit_cyc[1] - commit_cyc[0], 1);
            check("t1_back2back_b", commit_cyc[2] - commit_cyc[1], 1);
        end

        // Fill, refuse, commit one, wrap
        do_reset();
        for (int i = 0; i < 15; i++)
            dispatch(5'(i + 1), 1'b1, 1'b0, (i == 0), 32'h11);
        check("t2_full", to_decoder_full, 1'b1);
        from_decoder_valid = 1'b1;
        tick();
        from_decoder_valid = 1'b0;
        check("t2_refused_tag", to_decoder_rob_id, 4'd1);
        check("t2_still_full", to_decoder_full, 1'b1);
        cdb(4'd1, 32'h11, 1'b0, 32'h0);
        tick();
        check("t2_pending", exp_q.size(), 0);
        check("t2_not_full", to_decoder_full, 1'b0);
        dispatch(5'd20, 1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_refull", to_decoder_full, 1'b1);

        // rd=0 retires without a write
        do_reset();
        dispatch(5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        dispatch(5'd5, 1'b1, 1'b0, 1'b1, 32'h55);
        cdb(4'd1, 32'hAB, 1'b0, 32'h0);
        tick();
        check("t3_x0_no_write", to_rf_write_enabled, 1'b0);
        cdb(4'd2, 32'h55, 1'b0, 32'h0);
        tick();
        check("t3_pending", exp_q.size(), 0);
        check("t3_next_tag", to_decoder_rob_id, 4'd3);

        // Mispredicted branch flush
        do_reset();
        dispatch(5'd1, 1'b1, 1'b0, 1'b1, 32'h41);
        dispatch(5'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        dispatch(5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        dispatch(5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        dispatch(5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
        cdb(4'd1, 32'h41, 1'b0, 32'h0);
        cdb(4'd2, 32'h0, 1'b1, 32'h100);
        check("t4_tag1_committed", exp_q.size(), 0);
        check("t4_no_early_flush", flush_output, 1'b0);
        from_decoder_valid  = 1'b1;
        from_decoder_reg_id = 5'd9;
        cdb(4'd3, 32'h33, 1'b0, 32'h0);
        from_decoder_valid  = 1'b1;
        check("t4_flush", flush_output, 1'b1);
        check("t4_flush_pc", flush_pc, 32'h100);
        check("t4_flush_no_write", to_rf_write_enabled, 1'b0);
        check("t4_flush_full", to_decoder_full, 1'b1);
        tick();
        from_decoder_valid = 1'b0;
        check("t4_flush_one_cycle", flush_output, 1'b0);
        check("t4_tag_restart", to_decoder_rob_id, 4'd1);
        check("t4_empty_not_full", to_decoder_full, 1'b0);
        query_rob_id_a = 4'd3;
        #1;
        check("t4_tag3_discarded", query_ready_a, 1'b0);
        model_tag = 4'd1;
        dispatch(5'd7, 1'b1, 1'b0, 1'b1, 32'h77);
        cdb(4'd1, 32'h77, 1'b0, 32'h0);
        tick();
        check("t4_pending", exp_q.size(), 0);

        // Operand query
        do_reset();
        for (int i = 0; i < 4; i++)
            dispatch(5'(i + 1), 1'b1, 1'b0, 1'b0, 32'h0);
        query_rob_id_a = 4'd4;
        query_rob_id_b = 4'd0;
        #1;
        check("t5_before_ready", query_ready_a, 1'b0);
        cdb(4'd4, 32'hDEAD, 1'b0, 32'h0);
        check("t5_after_ready", query_ready_a, 1'b1);
        check("t5_after_data", query_data_a, 32'hDEAD);
        check("t5_tag0_ready", query_ready_b, 1'b0);
        check("t5_tag0_data", query_data_b, 32'h0);
        query_rob_id_b = 4'd4;
        #1;
        check("t5_port_b_ready", query_ready_b, 1'b1);
        check("t5_port_b_data", query_data_b, 32'hDEAD);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 6; i++)
            dispatch(5'(i + 1), 1'b1, 1'b0, (i == 0), 32'h66);
        cdb(4'd3, 32'h333, 1'b0, 32'h0);
        cdb(4'd1, 32'h66, 1'b0, 32'h0);
        tick();
        check("t6_pending", exp_q.size(), 0);
        query_rob_id_a = 4'd3;
        #1;
        check("t6_pre_rst_ready", query_ready_a, 1'b1);
        #1;
        rst_in = 1'b0;
        #1;
        check("t6_rst_rf_we", to_rf_write_enabled, 1'b0);
        check("t6_rst_rf_reg", to_rf_reg_id, 5'd0);
        check("t6_rst_rf_data", to_rf_data, 32'd0);
        check("t6_rst_rf_rob", to_rf_rob_id, 4'd0);
        check("t6_rst_rob_id", to_decoder_rob_id, 4'd1);
        check("t6_rst_full", to_decoder_full, 1'b0);
        check("t6_rst_query", query_ready_a, 1'b0);
        @(posedge clk_in);
        #1;
        rst_in    = 1'b1;
        model_tag = 4'd1;
        check("t6_post_query", query_ready_a, 1'b0);
        dispatch(5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        check("t6_post_tag", to_decoder_rob_id, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
